// File: rtl/mem_stage_controller_pkg.sv
// Shared types for the RV32I memory stage.
//   rv32i_types     : opcode and load/store funct3 encodings.
//   mem_stage_types : memory-stage FSM states and access-width classification.
// No ports (package file).

package rv32i_types;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef enum logic [2:0] {
      lb  = 3'b000,
      lh  = 3'b001,
      lw  = 3'b010,
      lbu = 3'b100,
      lhu = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      sb = 3'b000,
      sh = 3'b001,
      sw = 3'b010
   } store_funct3_t;

endpackage

package mem_stage_types;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } mem_state_t;

   typedef enum logic [1:0] {
      WIDTH_BYTE,
      WIDTH_HALF,
      WIDTH_WORD
   } mem_width_t;

   // funct3[1:0] carries the access size for both loads and stores;
   // the reserved 2'b11 size is treated as a full word.
   function automatic mem_width_t classify_width(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return WIDTH_BYTE;
         2'b01:   return WIDTH_HALF;
         default: return WIDTH_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_controller_if.sv
// Data-cache bus between the memory-stage controller and the cache.
//   data_addr  : word-aligned request address
//   data_read  : read request (held until data_resp)
//   data_write : write request (held until data_resp)
//   data_mbe   : byte enables
//   data_wdata : lane-aligned store data
//   data_resp  : cache completion strobe
//   data_rdata : cache read word, valid with data_resp
// master = controller side, slave = cache side.

interface mem_stage_controller_if;

   logic [31:0] data_addr;
   logic        data_read;
   logic        data_write;
   logic [3:0]  data_mbe;
   logic [31:0] data_wdata;
   logic        data_resp;
   logic [31:0] data_rdata;

   modport master (
      output data_addr, data_read, data_write, data_mbe, data_wdata,
      input  data_resp, data_rdata
   );

   modport slave (
      input  data_addr, data_read, data_write, data_mbe, data_wdata,
      output data_resp, data_rdata
   );

endinterface

// File: rtl/mem_stage_controller_load_extender.sv
// load_extender: combinational load-data alignment and extension.
//   funct3  in  3   load width/sign code
//   addr_lo in  2   byte offset of the access within the word
//   raw     in  32  word returned by the cache
//   ext     out 32  extended load result (reserved codes pass the raw word)

module load_extender
   import rv32i_types::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sgn);
      logic signed [31:0] s;
      s = $signed(b);
      return sgn ? s : {24'b0, b};
   endfunction

   function automatic logic [31:0] extend_half(input logic [15:0] h, input logic sgn);
      logic signed [31:0] s;
      s = $signed(h);
      return sgn ? s : {16'b0, h};
   endfunction

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = raw[7:0];
         2'd1:    byte_sel = raw[15:8];
         2'd2:    byte_sel = raw[23:16];
         default: byte_sel = raw[31:24];
      endcase
   end

   assign half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];

   always_comb begin
      case (funct3)
         lb:      ext = extend_byte(byte_sel, 1'b1);
         lh:      ext = extend_half(half_sel, 1'b1);
         lbu:     ext = extend_byte(byte_sel, 1'b0);
         lhu:     ext = extend_half(half_sel, 1'b0);
         default: ext = raw;
      endcase
   end

endmodule

// File: rtl/mem_stage_controller.sv
// mem_stage_controller: RV32I memory stage. Turns an EX/MEM load or store
// into a single held request on the data-cache bus, stalls the pipeline
// until the cache responds, and returns the extended load result.
//   clk, rst   : clock, asynchronous active-high reset
//   mem_valid  : EX/MEM holds a live instruction
//   opcode     : instruction opcode (only loads/stores are acted on)
//   funct3     : load/store width code
//   alu_out    : effective address
//   rs2_out    : store source data
//   dbus       : data-cache bus (master side)
//   stall      : freeze IF..EX/MEM (combinational)
//   load_data  : extended load result for MEM/WB
//   mem_done   : one-cycle pulse when the access completes
//   misaligned : current access is misaligned and suppressed

module mem_stage_controller
   import rv32i_types::*;
   import mem_stage_types::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          mem_valid,
   input  logic [6:0]                    opcode,
   input  logic [2:0]                    funct3,
   input  logic [31:0]                   alu_out,
   input  logic [31:0]                   rs2_out,
   mem_stage_controller_if.master        dbus,
   output logic                          stall,
   output logic [31:0]                   load_data,
   output logic                          mem_done,
   output logic                          misaligned
);

   mem_state_t  state, state_next;
   mem_width_t  width;
   logic        is_load;
   logic        is_mem;
   logic        start;
   logic [3:0]  mbe_calc;
   logic [31:0] wdata_calc;
   logic [31:0] load_ext;

   logic [31:0] addr_p1;
   logic [2:0]  funct3_p1;
   logic        is_load_p1;
   logic        read_p1;
   logic        write_p1;
   logic [3:0]  mbe_p1;
   logic [31:0] wdata_p1;
   logic [31:0] load_p1;

   assign is_load = (opcode == op_load);
   assign is_mem  = mem_valid & (is_load | (opcode == op_store));
   assign width   = classify_width(funct3);

   always_comb begin
      misaligned = 1'b0;
      if (is_mem) begin
         case (width)
            WIDTH_WORD: misaligned = (alu_out[1:0] != 2'b00);
            WIDTH_HALF: misaligned = alu_out[0];
            default:    misaligned = 1'b0;
         endcase
      end
   end

   // Loads always fetch the whole word; stores enable only their lanes.
   always_comb begin
      mbe_calc = 4'b1111;
      if (!is_load) begin
         case (width)
            WIDTH_BYTE: mbe_calc = 4'b0001 << alu_out[1:0];
            WIDTH_HALF: mbe_calc = 4'b0011 << alu_out[1:0];
            default:    mbe_calc = 4'b1111;
         endcase
      end
   end

   assign wdata_calc = rs2_out << {alu_out[1:0], 3'b000};

   assign start = (state == IDLE) & is_mem & ~misaligned;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // FSM next state
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = ACCESS;
         ACCESS:  if (dbus.data_resp) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      stall    = 1'b0;
      mem_done = 1'b0;
      case (state)
         IDLE:    stall    = is_mem & ~misaligned;
         ACCESS:  stall    = 1'b1;
         DONE:    mem_done = 1'b1;
         default: ;
      endcase
   end

   // Stage p1: request registers latched on entry to ACCESS, held until the response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_p1    <= '0;
         funct3_p1  <= '0;
         is_load_p1 <= 1'b0;
         read_p1    <= 1'b0;
         write_p1   <= 1'b0;
         mbe_p1     <= '0;
         wdata_p1   <= '0;
         load_p1    <= '0;
      end else if (start) begin
         addr_p1    <= alu_out;
         funct3_p1  <= funct3;
         is_load_p1 <= is_load;
         read_p1    <= is_load;
         write_p1   <= ~is_load;
         mbe_p1     <= mbe_calc;
         wdata_p1   <= wdata_calc;
      end else if ((state == ACCESS) && dbus.data_resp) begin
         read_p1  <= 1'b0;
         write_p1 <= 1'b0;
         if (is_load_p1) load_p1 <= load_ext;
      end
   end

   load_extender u_load_extender (
      .funct3  (funct3_p1),
      .addr_lo (addr_p1[1:0]),
      .raw     (dbus.data_rdata),
      .ext     (load_ext)
   );

   assign dbus.data_addr  = {addr_p1[31:2], 2'b00};
   assign dbus.data_read  = read_p1;
   assign dbus.data_write = write_p1;
   assign dbus.data_mbe   = mbe_p1;
   assign dbus.data_wdata = wdata_p1;

   // A suppressed misaligned load presents zero; the held result is untouched.
   assign load_data = misaligned ? 32'd0 : load_p1;

endmodule

// File: tb/tb_mem_stage_controller.sv
// Self-checking bench for mem_stage_controller: directed cases followed by
// randomized loads/stores checked against a behavioural reference model.

module tb_mem_stage_controller;
   import rv32i_types::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] alu_out;
   logic [31:0] rs2_out;
   logic        stall;
   logic [31:0] load_data;
   logic        mem_done;
   logic        misaligned;

   mem_stage_controller_if dbus ();

   mem_stage_controller dut (
      .clk        (clk),
      .rst        (rst),
      .mem_valid  (mem_valid),
      .opcode     (opcode),
      .funct3     (funct3),
      .alu_out    (alu_out),
      .rs2_out    (rs2_out),
      .dbus       (dbus),
      .stall      (stall),
      .load_data  (load_data),
      .mem_done   (mem_done),
      .misaligned (misaligned)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_load;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int size_bytes(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
      return (int'(addr[1:0]) % size_bytes(f3)) != 0;
   endfunction

   function automatic logic [3:0] model_mbe(input bit store, input logic [2:0] f3, input logic [31:0] addr);
      int n;
      if (!store) return 4'hF;
      n = size_bytes(f3);
      return 4'(((2 ** n) - 1) << int'(addr[1:0]));
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] rs2, input logic [31:0] addr);
      return rs2 << (8 * int'(addr[1:0]));
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
      int          n;
      logic [31:0] v;
      logic [31:0] mask;
      n = size_bytes(f3);
      if (n == 4 || f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return rdata;
      v    = rdata >> (8 * int'(addr[1:0]));
      mask = (32'h1 << (8 * n)) - 32'h1;
      v    = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   // Entered just after a rising edge; returns just after a rising edge.
   task automatic run_op(input bit valid, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input int wait_n,
                         input logic [31:0] rdata, input bit spurious,
                         output int stall_cnt, output int req_cnt, output int done_cnt,
                         output int cycles);
      bit is_mem, mis, is_store;
      stall_cnt = 0; req_cnt = 0; done_cnt = 0; cycles = 1;
      mem_valid = valid; opcode = opc; funct3 = f3; alu_out = addr; rs2_out = rs2;
      dbus.data_resp  = 1'($urandom_range(0, 1));
      dbus.data_rdata = $urandom;
      is_mem   = valid && (opc == op_load || opc == op_store);
      is_store = (opc == op_store);
      mis      = is_mem && model_misaligned(f3, addr);
      @(negedge clk);
      check_eq("misaligned", misaligned, mis);
      check_eq("idle_read", dbus.data_read, 0);
      check_eq("idle_write", dbus.data_write, 0);
      check_eq("idle_done", mem_done, 0);
      check_eq("idle_load", load_data, mis ? 32'd0 : exp_load);
      if (stall) stall_cnt++;
      if (!is_mem || mis) begin
         check_eq("nostall", stall, 0);
         @(posedge clk); #1;
         mem_valid = 1'b0; dbus.data_resp = 1'b0;
         return;
      end
      check_eq("idle_stall", stall, 1);
      for (int c = 1; c <= wait_n + 1; c++) begin
         @(posedge clk); #1;
         dbus.data_resp  = (c == wait_n + 1);
         dbus.data_rdata = (c == wait_n + 1) ? rdata : $urandom;
         @(negedge clk);
         cycles++;
         if (stall) stall_cnt++;
         if (dbus.data_read || dbus.data_write) req_cnt++;
         check_eq("acc_read", dbus.data_read, !is_store);
         check_eq("acc_write", dbus.data_write, is_store);
         check_eq("acc_addr", dbus.data_addr, {addr[31:2], 2'b00});
         check_eq("acc_mbe", dbus.data_mbe, model_mbe(is_store, f3, addr));
         if (is_store) check_eq("acc_wdata", dbus.data_wdata, model_wdata(rs2, addr));
         check_eq("acc_stall", stall, 1);
         check_eq("acc_done", mem_done, 0);
         check_eq("acc_load", load_data, exp_load);
      end
      if (!is_store) exp_load = model_load(f3, addr, rdata);
      @(posedge clk); #1;
      dbus.data_resp  = spurious;
      dbus.data_rdata = $urandom;
      @(negedge clk);
      cycles++;
      if (stall) stall_cnt++;
      if (dbus.data_read || dbus.data_write) req_cnt++;
      if (mem_done) done_cnt++;
      check_eq("done_pulse", mem_done, 1);
      check_eq("done_stall", stall, 0);
      check_eq("done_read", dbus.data_read, 0);
      check_eq("done_write", dbus.data_write, 0);
      check_eq("done_load", load_data, exp_load);
      @(posedge clk); #1;
      mem_valid = 1'b0; dbus.data_resp = 1'b0;
   endtask

   int sc, rc, dc, cy;

   initial begin
      rst = 1'b1; mem_valid = 1'b0; opcode = op_reg; funct3 = 3'b0;
      alu_out = '0; rs2_out = '0; dbus.data_resp = 1'b0; dbus.data_rdata = '0;
      exp_load = '0;
      #2;
      check_eq("rst_read", dbus.data_read, 0);
      check_eq("rst_write", dbus.data_write, 0);
      check_eq("rst_mbe", dbus.data_mbe, 0);
      check_eq("rst_wdata", dbus.data_wdata, 0);
      check_eq("rst_addr", dbus.data_addr, 0);
      check_eq("rst_load", load_data, 0);
      check_eq("rst_done", mem_done, 0);
      check_eq("rst_stall", stall, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // lw with two wait cycles
      run_op(1, op_load, lw, 32'h0000_1004, 32'h0, 2, 32'hDEAD_BEEF, 0, sc, rc, dc, cy);
      check_eq("lw_stall_cycles", sc, 4);
      check_eq("lw_read_cycles", rc, 3);
      check_eq("lw_done_pulses", dc, 1);
      check_eq("lw_value", load_data, 32'hDEAD_BEEF);

      // byte/half extraction
      run_op(1, op_load, lb, 32'h0000_2003, 32'h0, 0, 32'h80FF_FF7F, 0, sc, rc, dc, cy);
      check_eq("lb_value", load_data, 32'hFFFF_FF80);
      run_op(1, op_load, lbu, 32'h0000_2003, 32'h0, 1, 32'h80FF_FF7F, 0, sc, rc, dc, cy);
      check_eq("lbu_value", load_data, 32'h0000_0080);
      run_op(1, op_load, lhu, 32'h0000_2002, 32'h0, 0, 32'h80FF_FF7F, 0, sc, rc, dc, cy);
      check_eq("lhu_value", load_data, 32'h0000_80FF);
      run_op(1, op_load, 3'b110, 32'h0000_2000, 32'h0, 0, 32'h1234_5678, 0, sc, rc, dc, cy);
      check_eq("rsvd_value", load_data, 32'h1234_5678);

      // sb: write held across wait cycles; store leaves load_data alone
      run_op(1, op_store, sb, 32'h0000_3002, 32'h0000_00AB, 3, 32'h0, 0, sc, rc, dc, cy);
      check_eq("sb_write_cycles", rc, 4);
      check_eq("sb_keeps_load", load_data, 32'h1234_5678);

      // misaligned accesses are suppressed
      run_op(1, op_store, sh, 32'h0000_3001, 32'h1, 0, 32'h0, 0, sc, rc, dc, cy);
      check_eq("sh_mis_stall", sc, 0);
      run_op(1, op_load, lw, 32'h0000_3002, 32'h0, 0, 32'h0, 0, sc, rc, dc, cy);
      check_eq("lw_mis_stall", sc, 0);

      // non-memory and invalid instructions do nothing
      run_op(1, op_reg, 3'b010, 32'h0000_0003, 32'h0, 0, 32'h0, 0, sc, rc, dc, cy);
      run_op(0, op_load, lw, 32'h0000_0001, 32'h0, 0, 32'h0, 0, sc, rc, dc, cy);

      // back-to-back zero-wait stores, spurious response in DONE
      for (int i = 0; i < 2; i++) begin
         run_op(1, op_store, sw, 32'h0000_4000 + 32'(4 * i), 32'hCAFE_0000 + 32'(i), 0, 32'h0, 1, sc, rc, dc, cy);
         check_eq("sw_cycles", cy, 3);
         check_eq("sw_req_cycles", rc, 1);
      end

      // reset in the second ACCESS cycle
      mem_valid = 1'b1; opcode = op_load; funct3 = lw; alu_out = 32'h0000_5000;
      dbus.data_resp = 1'b0;
      @(negedge clk);
      check_eq("rr_stall", stall, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("rr_read_before", dbus.data_read, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_eq("rr_read", dbus.data_read, 0);
      check_eq("rr_write", dbus.data_write, 0);
      check_eq("rr_mbe", dbus.data_mbe, 0);
      check_eq("rr_addr", dbus.data_addr, 0);
      mem_valid = 1'b0;
      #1;
      check_eq("rr_idle_stall", stall, 0);
      exp_load = '0;
      check_eq("rr_load", load_data, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      run_op(1, op_load, lw, 32'h0000_6008, 32'h0, 1, 32'h0BAD_F00D, 0, sc, rc, dc, cy);
      check_eq("rr_lw_value", load_data, 32'h0BAD_F00D);
      check_eq("rr_lw_done", dc, 1);

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         int          kind;
         logic [6:0]  opc;
         logic [2:0]  f3;
         logic [31:0] addr;
         int          w;
         kind = $urandom_range(0, 9);
         addr = $urandom;
         w    = $urandom_range(0, 3);
         if (kind <= 4) begin
            opc = op_load;
            case ($urandom_range(0, 6))
               0: f3 = lb; 1: f3 = lh; 2: f3 = lw; 3: f3 = lbu; 4: f3 = lhu;
               5: begin f3 = 3'b111; addr[1:0] = 2'b00; end
               default: f3 = lw;
            endcase
         end else if (kind <= 8) begin
            opc = op_store;
            case ($urandom_range(0, 2))
               0: f3 = sb; 1: f3 = sh; default: f3 = sw;
            endcase
         end else begin
            opc = op_imm;
            f3  = 3'($urandom_range(0, 7));
         end
         run_op(($urandom_range(0, 9) != 0), opc, f3, addr, $urandom, w, $urandom,
                1'($urandom_range(0, 1)), sc, rc, dc, cy);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

endmodule
